nios_button_pio: RTL and testbench

Parametrised push-button input port for the Nios system: Avalon-MM slave that synchronises and debounces WIDTH button inputs, exposes debounced and raw levels, and latches qualifying edges into a write-one-to-clear capture register with a maskable interrupt. It is the next-generation replacement for the fixed 4-bit, level-only button port and sits on the same data-master bus, with `irq` routed to the CPU interrupt controller.

---
 rtl/nios_pio_pkg.sv | 20 ++
 rtl/nios_pio_debounce.sv | 77 +++++++
 rtl/nios_button_pio.sv | 89 ++++++++
 tb/tb_nios_button_pio.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// nios_button_pio shared definitions: register map, edge modes,
// debounce counter sizing.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    RISE = 2'd0,
    FALL = 2'd1,
    ANY  = 2'd2
  } edge_mode_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/nios_pio_debounce.sv
// One button channel: polarity, 2-flop sync, debouncer, edge pulses.
// Debouncer present only with NIOS_BUTTON_PIO_DEBOUNCE_EN defined.
module nios_pio_debounce
  import nios_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_err
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  logic pin_fix;
  logic s1;
  logic s2;
  logic stable_q;
  logic stable_d;

  assign pin_fix = ACTIVE_LOW ? ~pin : pin;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      s1 <= pin_fix;
      s2 <= s1;
      stable_q <= stable_d;
    end
  end

`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  // Any cycle of agreement drops the count back to zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d = '0;
    if (s2 != stable_q) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = s2;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end
`else
  assign stable_d = s2;
`endif

  assign raw = s2;
  assign stable = stable_q;
  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

endmodule

// File: rtl/nios_button_pio.sv
// Avalon-MM push-button port with edge capture and maskable irq.
// Define NIOS_BUTTON_PIO_DEBOUNCE_EN to enable the debouncers.
module nios_button_pio
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = 0,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_cfg_err
    $error("WIDTH must be 1..32");
  end

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd_mux;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    nios_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW != 0)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .raw    (raw[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign wr = chipselect && !write_n;
  assign wd = writedata[WIDTH-1:0];

  always_comb begin
    hit = rise | fall;
    if (EDGE_MODE == int'(RISE)) hit = rise;
    if (EDGE_MODE == int'(FALL)) hit = fall;
  end

  assign clr = (wr && address == ADDR_EDGECAP) ? wd : '0;

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:    rd_mux = 32'(stable);
      ADDR_RAW:     rd_mux = 32'(raw);
      ADDR_IRQMASK: rd_mux = 32'(irqmask);
      ADDR_EDGECAP: rd_mux = 32'(edgecap);
    endcase
  end

  // Set is ORed in after the clear so a same-cycle edge survives.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
      readdata <= '0;
    end else begin
      if (wr && address == ADDR_IRQMASK) irqmask <= wd;
      edgecap <= (edgecap & ~clr) | hit;
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_button_pio.sv
// Scoreboard bench for nios_button_pio (rising and any-edge builds).
// Expected latency follows NIOS_BUTTON_PIO_DEBOUNCE_EN.
module tb_nios_button_pio;
  import nios_pio_pkg::*;

  localparam int W = 4;
  localparam int N = 4;
`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
  localparam int L = N + 2;
  localparam bit DB = 1'b1;
`else
  localparam int L = 3;
  localparam bit DB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = ADDR_DATA;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [W-1:0] in_port = '1;
  logic [31:0]  rd_rise;
  logic [31:0]  rd_any;
  logic         irq_rise;
  logic         irq_any;

  always #5 clk = ~clk;

  nios_button_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE_MODE(0), .ACTIVE_LOW(1)
  ) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  nios_button_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(N), .EDGE_MODE(2), .ACTIVE_LOW(1)
  ) u_any (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  typedef struct {
    int          due;
    bit          any;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, e.any ? rd_any : rd_rise, e.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int dly,
                      input bit any, input logic [31:0] exp);
    q.push_back('{due: cyc + dly, any: any, tag: tag, exp: exp});
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input bit any, input logic [31:0] exp);
    address = a;
    push(tag, 1, any, exp);
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset while every button is held.
    in_port = '0;
    tick();
    repeat (3) tick();
    check("rst_rd_rise", rd_rise, 32'h0);
    check("rst_rd_any", rd_any, 32'h0);
    check("rst_irq", {31'b0, irq_rise | irq_any}, 32'h0);
    reset_n = 1'b1;
    rd("rel_edgecap", ADDR_EDGECAP, 1'b0, 32'h0);
    rd("rel_irqmask", ADDR_IRQMASK, 1'b0, 32'h0);
    repeat (2 * L) tick();
    rd("held_data", ADDR_DATA, 1'b0, 32'hF);
    rd("held_raw", ADDR_RAW, 1'b0, 32'hF);
    rd("held_edgecap", ADDR_EDGECAP, 1'b0, 32'hF);
    rd("held_edgecap_any", ADDR_EDGECAP, 1'b1, 32'hF);
    in_port = '1;
    repeat (2 * L) tick();
    rd("free_data", ADDR_DATA, 1'b0, 32'h0);
    rd("free_raw", ADDR_RAW, 1'b0, 32'h0);
    rd("free_edgecap", ADDR_EDGECAP, 1'b0, 32'hF);
    wr(ADDR_EDGECAP, 32'hFFFF_FFFF);
    rd("clr_edgecap", ADDR_EDGECAP, 1'b0, 32'h0);

    // Latency from pin to DATA.
    address = ADDR_DATA;
    in_port[0] = 1'b0;
    push("lat_data_pre", L, 1'b0, 32'h0);
    push("lat_data", L + 1, 1'b0, 32'h1);
    repeat (L + 1) tick();
    rd("lat_edgecap", ADDR_EDGECAP, 1'b0, 32'h1);
    in_port[0] = 1'b1;
    repeat (2 * L) tick();
    wr(ADDR_EDGECAP, 32'hF);

    // Short glitch, then a press just long enough.
    in_port[1] = 1'b0;
    repeat (N - 1) tick();
    in_port[1] = 1'b1;
    repeat (2 * L) tick();
    rd("glitch_data", ADDR_DATA, 1'b0, 32'h0);
    rd("glitch_edgecap", ADDR_EDGECAP, 1'b0, DB ? 32'h0 : 32'h2);
    wr(ADDR_EDGECAP, 32'hF);
    in_port[1] = 1'b0;
    repeat (N) tick();
    in_port[1] = 1'b1;
    repeat (2 * L) tick();
    rd("press_n_edgecap", ADDR_EDGECAP, 1'b0, 32'h2);
    wr(ADDR_EDGECAP, 32'hF);

    // Masked interrupt.
    wr(ADDR_IRQMASK, 32'hFFFF_FFF2);
    rd("irqmask_rd", ADDR_IRQMASK, 1'b0, 32'h2);
    in_port[0] = 1'b0;
    repeat (L + 1) tick();
    check("irq_ch0", {31'b0, irq_rise}, 32'h0);
    rd("irq_ch0_edgecap", ADDR_EDGECAP, 1'b0, 32'h1);
    in_port[1] = 1'b0;
    repeat (L + 1) tick();
    check("irq_ch1", {31'b0, irq_rise}, 32'h1);
    wr(ADDR_EDGECAP, 32'h2);
    check("irq_clr", {31'b0, irq_rise}, 32'h0);
    rd("irq_clr_edgecap", ADDR_EDGECAP, 1'b0, 32'h1);

    // Clear on the very edge that sets bit 2.
    in_port[2] = 1'b0;
    repeat (L - 1) tick();
    wr(ADDR_EDGECAP, 32'h4);
    rd("setwins_edgecap", ADDR_EDGECAP, 1'b0, 32'h5);
    check("setwins_irq_m2", {31'b0, irq_rise}, 32'h0);
    wr(ADDR_IRQMASK, 32'h4);
    check("setwins_irq_m4", {31'b0, irq_rise}, 32'h1);
    in_port = '1;
    repeat (2 * L) tick();
    wr(ADDR_EDGECAP, 32'hF);
    wr(ADDR_IRQMASK, 32'h0);
    check("idle_irq", {31'b0, irq_rise | irq_any}, 32'h0);

    // Any-edge capture on channel 3.
    in_port[3] = 1'b0;
    repeat (2 * L) tick();
    rd("any_press", ADDR_EDGECAP, 1'b1, 32'h8);
    rd("rise_press", ADDR_EDGECAP, 1'b0, 32'h8);
    wr(ADDR_EDGECAP, 32'hF);
    in_port[3] = 1'b1;
    repeat (2 * L) tick();
    rd("any_release", ADDR_EDGECAP, 1'b1, 32'h8);
    rd("rise_release", ADDR_EDGECAP, 1'b0, 32'h0);

    repeat (3) tick();
    if (q.size() != 0) check("drain", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
